cb_shift_engine: RTL and testbench
==================================

Name: cb_shift_engine

Overview:
- Parametrised multi-cycle successor to the Z80 CB-prefix rotate/shift group (RLC, RRC, RL, RR, SLA, SRA, SLL, SRL), sitting beside the tv80 core as a coprocessor-style ALU extension.
- Generalised from a fixed 8-bit, single-shift operation to DATA_W-bit operands and a variable shift count.
- Executes one bit position per clock, with a start/busy/done handshake.
- Produces Z80-format flags for the final result.

Parameters:
- DATA_W, 8: operand/result width in bits; legal values 8 and 16.
- CNT_W, 4: width of the shift-count input; max count 2**CNT_W-1.

Ports:
- clk  in  1  single system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only when not busy.
- op  in  3  operation, Z80 opcode bits 5:3: 000 RLC, 001 RRC, 010 RL, 011 RR, 100 SLA, 101 SRA, 110 SLL, 111 SRL.
- count  in  CNT_W  number of single-bit steps, sampled with start.
- din  in  DATA_W  operand, sampled with start.
- cin  in  1  incoming carry, used by RL/RR and for the count=0 result.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse when dout/flags become valid.
- dout  out  DATA_W  result; held until the next accepted start.
- flags  out  8  Z80 F: S Z Y H X P/V N C (bit 7..0).

Behaviour:
- Reset is asynchronous and active-low; clock and reset are fixed as above.
  - On reset: FSM=IDLE; busy=0, done=0, dout=0, flags=0, internal carry=0.
  - Reset mid-operation aborts immediately; no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE + start: latch op, din, cin (into internal carry), count. count!=0 -> SHIFT; count==0 -> DONE.
  - SHIFT: one step per cycle; the remaining counter decrements; after the step that takes it to 0 -> DONE.
  - DONE: done=1 for exactly one cycle; dout/flags are updated on entry.
    - Next state is IDLE.
    - If start is high in DONE, the request is accepted exactly as from IDLE.
- busy=1 in SHIFT only. start while busy is ignored, with no queuing.
- Latency: done is asserted count+1 rising edges after the edge that sampled start; count=0 gives latency 1.
- Step semantics (msb = bit DATA_W-1, C = internal carry):
  - RLC: C<=msb; r<={r[msb-1:0],msb}.
  - RRC: C<=lsb; r<={lsb,r[msb:1]}.
  - RL: C<=msb; r<={r[msb-1:0],C}.
  - RR: C<=lsb; r<={C,r[msb:1]}.
  - SLA: C<=msb; shift in 0.
  - SRA: C<=lsb; msb preserved.
  - SLL: C<=msb; shift in 1.
  - SRL: C<=lsb; shift in 0.
- Counts greater than DATA_W are legal; rotates wrap and shifts saturate naturally.
- Flags on final result r:
  - S = r[msb]; Z = (r==0) over the full width.
  - Y = r[5]; X = r[3].
  - H = 0; N = 0.
  - P/V = even parity of all DATA_W bits (1 if even).
  - C = internal carry after the last step.
  - count=0: r = din and C = cin; the other flags are computed from din.
- flags and dout change only on entry to DONE.

Optional Feature:
- Macro: CB_SHIFT_SLL_EN.
- Defined: op 110 = SLL (shift left, insert 1), the undocumented Z80 behaviour.
- Undefined: op 110 executes as SLA (insert 0), with identical timing and flag rules; no SLL logic is synthesised.

Test Plan:
- DATA_W=8, macro defined, op=SLL, din=0x44, count=1 -> done at edge 2; dout=0x89, flags=0x88; busy high exactly 1 cycle.
- Same stimulus with macro undefined -> dout=0x88, flags=0x8C.
- DATA_W=8, op=SRA, din=0x81, count=2 -> done at edge 3; dout=0xE0, flags=0xA0. Then op=RLC, din=0x80, count=1 -> dout=0x01, flags=0x01.
- DATA_W=16, op=RR, din=0x0001, cin=1, count=1 -> dout=0x8000, flags=0x81. Then count=0, din=0x0000, cin=1 -> done at edge 1; dout=0x0000, flags=0x45.
- Handshake:
  - Pulse start again while busy (op=SRL, count=5) -> ignored; exactly one done pulse, 6 edges after the first start.
  - start held high during DONE -> a new operation is accepted back-to-back.
- Assert reset_n low asynchronously mid-SHIFT (count=10, after 3 steps) -> busy, done, dout and flags go to 0 immediately; no done pulse after release; the next start operates normally.

Source files
------------

// File: rtl/cb_shift_engine.sv
// Multi-cycle CB-group rotate/shift engine: one bit step per clock, Z80-format flags on the result.
// Optional feature macro: CB_SHIFT_SLL_EN (op 110 inserts 1 when defined, behaves as SLA otherwise).
module cb_shift_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] din,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic [7:0]        flags
);

`ifdef CB_SHIFT_SLL_EN
    localparam logic SllFill = 1'b1;
`else
    localparam logic SllFill = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dout;
    logic [7:0]        r_flags;

    logic              w_accept;
    logic              w_last_step;
    logic              w_msb;
    logic              w_lsb;
    logic [DATA_W-1:0] w_step_data;
    logic              w_step_carry;

    function automatic logic [7:0] calc_flags(input logic [DATA_W-1:0] v, input logic c);
        return {v[DATA_W-1], (v == '0), v[5], 1'b0, v[3], ~^v, 1'b0, c};
    endfunction

    // DONE is a one-cycle state that can also accept a new request back-to-back
    assign w_accept    = start && (r_state != StShift);
    assign w_last_step = (r_state == StShift) && (r_cnt == CNT_W'(1));
    assign w_msb       = r_data[DATA_W-1];
    assign w_lsb       = r_data[0];

    always_comb begin
        w_step_data  = r_data;
        w_step_carry = r_carry;
        unique case (r_op)
            3'b000: begin w_step_data = {r_data[DATA_W-2:0], w_msb};   w_step_carry = w_msb; end
            3'b001: begin w_step_data = {w_lsb, r_data[DATA_W-1:1]};   w_step_carry = w_lsb; end
            3'b010: begin w_step_data = {r_data[DATA_W-2:0], r_carry}; w_step_carry = w_msb; end
            3'b011: begin w_step_data = {r_carry, r_data[DATA_W-1:1]}; w_step_carry = w_lsb; end
            3'b100: begin w_step_data = {r_data[DATA_W-2:0], 1'b0};    w_step_carry = w_msb; end
            3'b101: begin w_step_data = {w_msb, r_data[DATA_W-1:1]};   w_step_carry = w_lsb; end
            3'b110: begin w_step_data = {r_data[DATA_W-2:0], SllFill}; w_step_carry = w_msb; end
            3'b111: begin w_step_data = {1'b0, r_data[DATA_W-1:1]};    w_step_carry = w_lsb; end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = (count == '0) ? StDone : StShift;
            StShift: if (w_last_step) w_state_next = StDone;
            StDone:  w_state_next = start ? ((count == '0) ? StDone : StShift) : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= 3'b000;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_flags <= 8'h00;
        end else if (w_accept) begin
            r_op    <= op;
            r_data  <= din;
            r_carry <= cin;
            r_cnt   <= count;
            if (count == '0) begin
                r_dout  <= din;
                r_flags <= calc_flags(din, cin);
            end
        end else if (r_state == StShift) begin
            r_data  <= w_step_data;
            r_carry <= w_step_carry;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (w_last_step) begin
                r_dout  <= w_step_data;
                r_flags <= calc_flags(w_step_data, w_step_carry);
            end
        end
    end

    assign busy  = (r_state == StShift);
    assign done  = (r_state == StDone);
    assign dout  = r_dout;
    assign flags = r_flags;

endmodule

// File: tb/tb_cb_shift_engine.sv
// Bench for cb_shift_engine: 8-bit and 16-bit instances driven in parallel against a reference model.
module tb_cb_shift_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [3:0]  count = 4'd0;
    logic [15:0] din = 16'h0000;
    logic        cin = 1'b0;

    logic        busy8, done8, busy16, done16;
    logic [7:0]  dout8, flags8, flags16;
    logic [15:0] dout16;

    int n_checks = 0;
    int n_pass   = 0;

    // expected (currently presented) and pending (after next DONE) results
    logic [15:0] exp_r8 = 16'h0, exp_r16 = 16'h0, pend_r8, pend_r16;
    logic [7:0]  exp_f8 = 8'h0, exp_f16 = 8'h0, pend_f8, pend_f16;

    always #5 clk = ~clk;

    cb_shift_engine #(.DATA_W(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .count(count),
        .din(din[7:0]), .cin(cin), .busy(busy8), .done(done8), .dout(dout8), .flags(flags8)
    );

    cb_shift_engine #(.DATA_W(16), .CNT_W(4)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .count(count),
        .din(din), .cin(cin), .busy(busy16), .done(done16), .dout(dout16), .flags(flags16)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: repeat the single-bit rule cnt times using integer arithmetic.
    function automatic void model(input int w, input logic [2:0] o, input int cnt,
                                  input logic [15:0] d, input logic ci,
                                  output logic [15:0] r, output logic [7:0] f);
        int unsigned mask, v, c, hi, lo, fill;
        mask = (32'd1 << w) - 1;
        v = d & mask;
        c = ci;
`ifdef CB_SHIFT_SLL_EN
        fill = 1;
`else
        fill = 0;
`endif
        for (int i = 0; i < cnt; i++) begin
            hi = (v >> (w - 1)) & 1;
            lo = v & 1;
            case (o)
                3'd0: begin v = (v << 1) | hi;            c = hi; end
                3'd1: begin v = (v >> 1) | (lo << (w-1)); c = lo; end
                3'd2: begin v = (v << 1) | c;             c = hi; end
                3'd3: begin v = (v >> 1) | (c << (w-1));  c = lo; end
                3'd4: begin v = v << 1;                   c = hi; end
                3'd5: begin v = (v >> 1) | (hi << (w-1)); c = lo; end
                3'd6: begin v = (v << 1) | fill;          c = hi; end
                default: begin v = v >> 1;                c = lo; end
            endcase
            v = v & mask;
        end
        r = v[15:0];
        f = 8'h00;
        f[7] = v[w-1];
        f[6] = (v == 0);
        f[5] = v[5];
        f[3] = v[3];
        f[2] = ($countones(v) % 2 == 0);
        f[0] = c[0];
    endfunction

    // Drive a request (call at a negedge); the model result becomes pending.
    task automatic issue(input logic [2:0] o, input int cnt, input logic [15:0] d, input logic ci);
        start = 1'b1;
        op    = o;
        count = cnt[3:0];
        din   = d;
        cin   = ci;
        model(8, o, cnt, d, ci, pend_r8, pend_f8);
        model(16, o, cnt, d, ci, pend_r16, pend_f16);
    endtask

    // Sampling edge, then check busy/done/dout/flags at each following negedge up to DONE.
    // glitch_k >= 0 pulses a conflicting start at that negedge while busy.
    task automatic track(input int cnt, input int glitch_k);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= cnt; k++) begin
            @(negedge clk);
            start = (k == glitch_k);
            if (k == glitch_k) begin
                op  = 3'd0;
                din = 16'hA5C3;
            end
            if (k == cnt) begin
                exp_r8  = pend_r8;  exp_f8  = pend_f8;
                exp_r16 = pend_r16; exp_f16 = pend_f16;
            end
            chk("busy8",  {15'd0, busy8},  {15'd0, (k < cnt)});
            chk("busy16", {15'd0, busy16}, {15'd0, (k < cnt)});
            chk("done8",  {15'd0, done8},  {15'd0, (k == cnt)});
            chk("done16", {15'd0, done16}, {15'd0, (k == cnt)});
            chk("dout8",   {8'd0, dout8},  exp_r8);
            chk("flags8",  {8'd0, flags8}, {8'd0, exp_f8});
            chk("dout16",  dout16,         exp_r16);
            chk("flags16", {8'd0, flags16}, {8'd0, exp_f16});
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done8"},  {15'd0, done8},  16'd0);
        chk({tag, "_done16"}, {15'd0, done16}, 16'd0);
        chk({tag, "_busy8"},  {15'd0, busy8},  16'd0);
        chk({tag, "_dout8"},  {8'd0, dout8},   exp_r8);
        chk({tag, "_dout16"}, dout16,          exp_r16);
    endtask

    initial begin
        int rc;
        int r_op;
        // Reset state
        #2;
        chk("rst_busy8",  {15'd0, busy8},  16'd0);
        chk("rst_done8",  {15'd0, done8},  16'd0);
        chk("rst_dout8",  {8'd0, dout8},   16'd0);
        chk("rst_flags8", {8'd0, flags8},  16'd0);
        chk("rst_dout16", dout16,          16'd0);
        chk("rst_flags16", {8'd0, flags16}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // op 110 with din=0x44, count=1
        issue(3'd6, 1, 16'h0044, 1'b0);
        track(1, -1);
`ifdef CB_SHIFT_SLL_EN
        chk("sll_dout",  {8'd0, dout8},  16'h0089);
        chk("sll_flags", {8'd0, flags8}, 16'h0088);
`else
        chk("sll_dout",  {8'd0, dout8},  16'h0088);
        chk("sll_flags", {8'd0, flags8}, 16'h008C);
`endif
        idle_check("idle1");

        // SRA 0x81 x2, then RLC 0x80 x1
        issue(3'd5, 2, 16'h0081, 1'b0);
        track(2, -1);
        chk("sra_dout",  {8'd0, dout8},  16'h00E0);
        chk("sra_flags", {8'd0, flags8}, 16'h00A0);
        idle_check("idle2");
        issue(3'd0, 1, 16'h0080, 1'b0);
        track(1, -1);
        chk("rlc_dout",  {8'd0, dout8},  16'h0001);
        chk("rlc_flags", {8'd0, flags8}, 16'h0001);
        idle_check("idle3");

        // RR 16-bit with carry in, then count=0 pass-through
        issue(3'd3, 1, 16'h0001, 1'b1);
        track(1, -1);
        chk("rr16_dout",  dout16,          16'h8000);
        chk("rr16_flags", {8'd0, flags16}, 16'h0081);
        idle_check("idle4");
        issue(3'd3, 0, 16'h0000, 1'b1);
        track(0, -1);
        chk("cnt0_dout16",  dout16,          16'h0000);
        chk("cnt0_flags16", {8'd0, flags16}, 16'h0045);
        idle_check("idle5");

        // start while busy is ignored; exactly one done
        issue(3'd7, 5, 16'hF00F, 1'b0);
        track(5, 2);
        for (int i = 0; i < 4; i++) idle_check("noq");

        // back-to-back: new request accepted while in DONE
        issue(3'd2, 3, 16'h1234, 1'b1);
        track(3, -1);
        issue(3'd1, 2, 16'h8001, 1'b0);
        track(2, -1);
        idle_check("b2b");

        // asynchronous reset mid-shift
        issue(3'd0, 10, 16'h5A3C, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        exp_r8 = 16'h0; exp_f8 = 8'h0; exp_r16 = 16'h0; exp_f16 = 8'h0;
        chk("arst_busy8",  {15'd0, busy8},  16'd0);
        chk("arst_done8",  {15'd0, done8},  16'd0);
        chk("arst_dout8",  {8'd0, dout8},   16'd0);
        chk("arst_flags8", {8'd0, flags8},  16'd0);
        chk("arst_busy16", {15'd0, busy16}, 16'd0);
        chk("arst_dout16", dout16,          16'd0);
        chk("arst_flags16", {8'd0, flags16}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) idle_check("post_rst");
        issue(3'd4, 3, 16'h00C3, 1'b1);
        track(3, -1);

        // randomized operations
        for (int n = 0; n < 30; n++) begin
            r_op = $urandom_range(0, 7);
            rc = $urandom_range(0, 15);
            issue(r_op[2:0], rc, 16'($urandom), 1'($urandom));
            track(rc, -1);
            if ($urandom_range(0, 1) == 1) idle_check("rnd_idle");
        end
        idle_check("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
